axi_inf_write_slave_core: RTL

- AXI4 write-channel responder (slave end) for the write-burst state cores used by the VDMA masters.
- Accepts one AW burst at a time and its W beats, and checks WLAST against AWLEN.
- Forwards each accepted beat to a simple local memory/FIFO write port, then returns a B response with the captured ID.
- Used as the memory-side model and as the slave of on-chip interconnect bridges.

---
 rtl/axi_inf_write_slave_core.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_inf_write_slave_core.sv
// ---------------------------------------------------------------------------
// axi_inf_write_slave_core
//
// AXI4 write-channel responder. Takes one AW burst at a time and its W beats,
// forwards each accepted beat to a local memory/FIFO write port, and returns
// a B response carrying the captured ID. WLAST is checked against AWLEN:
// an early WLAST or a missing WLAST ends the burst with SLVERR. Surplus beats
// after the last expected one are drained without being written. WRAP bursts
// are addressed as INCR but flagged with SLVERR.
//
// Ports:
//   axi_aclk, axi_resetn          clock, asynchronous active-low reset
//   axi_aw*                       write address channel (id, addr, len, burst)
//   axi_w*                        write data channel (data, strb, last)
//   axi_b*                        write response channel (id, resp)
//   mem_wr_full                   local sink back-pressure
//   mem_wr_en/addr/data/strb      registered local write port, one per beat
//   burst_done, burst_err         one-cycle pulse after the B handshake
// ---------------------------------------------------------------------------
module axi_inf_write_slave_core #(
  parameter int IDSIZE    = 3,
  parameter int LSIZE     = 8,
  parameter int ASIZE     = 32,
  parameter int DSIZE     = 256,
  parameter int ADDR_STEP = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  input  logic                 mem_wr_full,
  output logic                 mem_wr_en,
  output logic [ASIZE-1:0]     mem_wr_addr,
  output logic [DSIZE-1:0]     mem_wr_data,
  output logic [DSIZE/8-1:0]   mem_wr_strb,
  output logic                 burst_done,
  output logic                 burst_err
);

  localparam int SSIZE = DSIZE / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    DRAIN    = 2'd2,
    SEND_B   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Burst context captured at the AW handshake
  logic [IDSIZE-1:0] id_reg;
  logic [ASIZE-1:0]  addr_reg;
  logic [LSIZE-1:0]  len_reg;
  logic [1:0]        burst_reg;
  logic [LSIZE-1:0]  count_reg;
  logic              err_reg, err_next;

  // Registered outputs
  logic              awready_reg;
  logic              bvalid_reg;
  logic [IDSIZE-1:0] bid_reg;
  logic [1:0]        bresp_reg;
  logic              mem_wr_en_reg;
  logic [ASIZE-1:0]  mem_wr_addr_reg;
  logic [DSIZE-1:0]  mem_wr_data_reg;
  logic [SSIZE-1:0]  mem_wr_strb_reg;
  logic              burst_done_reg;
  logic              burst_err_reg;

  // Combinational strobes
  logic wready;
  logic aw_fire;
  logic beat_write;   // beat accepted and forwarded to the local port
  logic b_fire;

  // -------------------------------------------------------------------------
  // Next-state / strobe logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    wready     = 1'b0;
    aw_fire    = 1'b0;
    beat_write = 1'b0;
    b_fire     = 1'b0;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        // awready_reg is low only in the first cycle after reset release
        aw_fire = axi_awvalid & awready_reg;
        if (aw_fire) begin
          state_next = GET_DATA;
          // WRAP (and the reserved encoding) is addressed as INCR but reported
          err_next   = axi_awburst[1];
        end
      end

      GET_DATA: begin
        wready = !mem_wr_full;
        if (axi_wvalid && wready) begin
          beat_write = 1'b1;
          if (axi_wlast) begin
            state_next = SEND_B;
            if (count_reg != len_reg) begin
              err_next = 1'b1;
            end
          end else if (count_reg == len_reg) begin
            // Final expected beat without WLAST: written, rest is discarded
            state_next = DRAIN;
            err_next   = 1'b1;
          end
        end
      end

      DRAIN: begin
        // Discarded beats do not touch the sink, so back-pressure is ignored
        wready = 1'b1;
        if (axi_wvalid && axi_wlast) begin
          state_next = SEND_B;
        end
      end

      SEND_B: begin
        b_fire = bvalid_reg & axi_bready;
        if (b_fire) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Burst context, beat counter and address generation
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      burst_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= err_next;
      if (aw_fire) begin
        id_reg    <= axi_awid;
        addr_reg  <= axi_awaddr;
        len_reg   <= axi_awlen;
        burst_reg <= axi_awburst;
        count_reg <= '0;
      end else if (beat_write) begin
        // Counter stops at len so it can never wrap for len = all ones
        if (count_reg != len_reg) begin
          count_reg <= count_reg + 1'b1;
        end
        if (burst_reg != 2'b00) begin
          addr_reg <= addr_reg + ASIZE'(ADDR_STEP);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered channel outputs and local write port
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      awready_reg     <= 1'b0;
      bvalid_reg      <= 1'b0;
      bid_reg         <= '0;
      bresp_reg       <= 2'b00;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_addr_reg <= '0;
      mem_wr_data_reg <= '0;
      mem_wr_strb_reg <= '0;
      burst_done_reg  <= 1'b0;
      burst_err_reg   <= 1'b0;
    end else begin
      awready_reg <= (state_next == IDLE);
      bvalid_reg  <= (state_next == SEND_B);
      bid_reg     <= (state_next == SEND_B) ? id_reg : '0;
      bresp_reg   <= ((state_next == SEND_B) && err_next) ? 2'b10 : 2'b00;

      mem_wr_en_reg <= beat_write;
      if (beat_write) begin
        mem_wr_addr_reg <= addr_reg;
        mem_wr_data_reg <= axi_wdata;
        mem_wr_strb_reg <= axi_wstrb;
      end

      burst_done_reg <= b_fire;
      burst_err_reg  <= b_fire & err_reg;
    end
  end

  assign axi_awready = awready_reg;
  assign axi_wready  = wready;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bid     = bid_reg;
  assign axi_bresp   = bresp_reg;
  assign mem_wr_en   = mem_wr_en_reg;
  assign mem_wr_addr = mem_wr_addr_reg;
  assign mem_wr_data = mem_wr_data_reg;
  assign mem_wr_strb = mem_wr_strb_reg;
  assign burst_done  = burst_done_reg;
  assign burst_err   = burst_err_reg;

endmodule
